hazard_scoreboard: RTL and testbench

//  Parametrised successor of the fixed-table stall controller. Tracks in-flight GRF writes in a

---
 rtl/hazard_scoreboard.sv | 113 +++++++++++
 tb/tb_hazard_scoreboard.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// D-stage hazard scoreboard: shift-register record of in-flight GRF writes plus an MD busy counter.
// Stall and forward selects are combinational from registered state and D inputs; hold freezes the back end.
module hazard_scoreboard #(
    parameter int ADDR_W  = 5,
    parameter int TNEW_W  = 2,
    parameter int STAGES  = 3,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    localparam int FWD_W  = $clog2(STAGES + 1),
    localparam int MD_W   = $clog2(((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT) + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              flush,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic              use_a1,
    input  logic              use_a2,
    input  logic [TNEW_W-1:0] tuse_a1,
    input  logic [TNEW_W-1:0] tuse_a2,
    input  logic              d_regwrite,
    input  logic [ADDR_W-1:0] d_a3,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic              d_md_use,
    input  logic [1:0]        d_md_start,
    output logic              stall,
    output logic [FWD_W-1:0]  fwd_a1,
    output logic [FWD_W-1:0]  fwd_a2,
    output logic              md_busy
);

    // Index k is the stage k cycles past D: 1 = E, 2 = M, ...
    logic [STAGES:1]   valid_q, valid_d;
    logic [ADDR_W-1:0] a3_q   [1:STAGES];
    logic [ADDR_W-1:0] a3_d   [1:STAGES];
    logic [TNEW_W-1:0] tnew_q [1:STAGES];
    logic [TNEW_W-1:0] tnew_d [1:STAGES];
    logic [MD_W-1:0]   md_cnt_q, md_cnt_d;

    logic haz_a1, haz_a2, md_hazard, issue;

    // Scanning oldest to youngest lets the youngest match overwrite older ones.
    always_comb begin
        fwd_a1 = '0;
        fwd_a2 = '0;
        haz_a1 = 1'b0;
        haz_a2 = 1'b0;
        for (int k = STAGES; k >= 1; k--) begin
            if (valid_q[k] && use_a1 && (a1 != '0) && (a3_q[k] == a1)) begin
                fwd_a1 = FWD_W'(k);
                haz_a1 = (tnew_q[k] > tuse_a1);
            end
            if (valid_q[k] && use_a2 && (a2 != '0) && (a3_q[k] == a2)) begin
                fwd_a2 = FWD_W'(k);
                haz_a2 = (tnew_q[k] > tuse_a2);
            end
        end
        md_busy   = (md_cnt_q != '0);
        md_hazard = d_md_use && md_busy;
        stall     = (d_valid && (haz_a1 || haz_a2 || md_hazard)) || hold;
        issue     = d_valid && !stall && !hold;
    end

    always_comb begin
        valid_d  = valid_q;
        md_cnt_d = md_cnt_q;
        for (int k = 1; k <= STAGES; k++) begin
            a3_d[k]   = a3_q[k];
            tnew_d[k] = tnew_q[k];
        end

        if (flush) begin
            valid_d = '0;
        end else if (!hold) begin
            for (int k = STAGES; k >= 2; k--) begin
                valid_d[k] = valid_q[k-1];
                a3_d[k]    = a3_q[k-1];
                tnew_d[k]  = (tnew_q[k-1] != '0) ? (tnew_q[k-1] - TNEW_W'(1)) : '0;
            end
            valid_d[1] = issue && d_regwrite && (d_a3 != '0);
            a3_d[1]    = d_a3;
            tnew_d[1]  = d_tnew;
        end

        // The MD unit keeps counting while the back end is held or flushed.
        if (issue && (d_md_start != 2'b00)) begin
            md_cnt_d = d_md_start[1] ? MD_W'(DIV_LAT) : MD_W'(MUL_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            md_cnt_q <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                a3_q[k]   <= '0;
                tnew_q[k] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            md_cnt_q <= md_cnt_d;
            for (int k = 1; k <= STAGES; k++) begin
                a3_q[k]   <= a3_d[k];
                tnew_q[k] <= tnew_d[k];
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard with hand-computed stall/forward expectations.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset, hold, flush, d_valid;
    logic [4:0] a1, a2, d_a3;
    logic       use_a1, use_a2, d_regwrite, d_md_use;
    logic [1:0] tuse_a1, tuse_a2, d_tnew, d_md_start;
    logic       stall, md_busy;
    logic [1:0] fwd_a1, fwd_a2;

    int n_vec = 0;
    int n_err = 0;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .d_valid(d_valid),
        .a1(a1), .a2(a2), .use_a1(use_a1), .use_a2(use_a2),
        .tuse_a1(tuse_a1), .tuse_a2(tuse_a2), .d_regwrite(d_regwrite), .d_a3(d_a3),
        .d_tnew(d_tnew), .d_md_use(d_md_use), .d_md_start(d_md_start),
        .stall(stall), .fwd_a1(fwd_a1), .fwd_a2(fwd_a2), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [4:0] ra1, input logic u1, input logic [1:0] t1,
                       input logic [4:0] ra2, input logic u2, input logic [1:0] t2,
                       input logic rw, input logic [4:0] wa, input logic [1:0] tn,
                       input logic mu, input logic [1:0] ms);
        d_valid = v;  a1 = ra1; use_a1 = u1; tuse_a1 = t1;
        a2 = ra2; use_a2 = u2; tuse_a2 = t2;
        d_regwrite = rw; d_a3 = wa; d_tnew = tn; d_md_use = mu; d_md_start = ms;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 2'b00);
    endtask

    task automatic wr(input logic [4:0] wa, input logic [1:0] tn);
        drv(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, wa, tn, 1'b0, 2'b00);
    endtask

    // Lets the current D instruction issue, then empties every stage.
    task automatic drain();
        tick();
        idle();
        repeat (3) tick();
    endtask

    // Start an MD op, then hold an mflo in D and expect exactly lat stalled cycles.
    task automatic md_run(input string tag, input logic [1:0] start, input int lat);
        tick();
        drv(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b1, start);
        @(negedge clk);
        chk({tag, "_start_stall"}, stall, 0);
        tick();
        drv(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b1, 2'b00);
        for (int i = 0; i <= lat + 1; i++) begin
            @(negedge clk);
            chk($sformatf("%s_stall_c%0d", tag, i), stall, (i < lat) ? 1 : 0);
            chk($sformatf("%s_busy_c%0d", tag, i), md_busy, (i < lat) ? 1 : 0);
            tick();
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; hold = 1'b0; flush = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_fwd1", fwd_a1, 0);
        chk("rst_fwd2", fwd_a2, 0);
        chk("rst_busy", md_busy, 0);
        hold = 1'b1;
        #1 chk("hold_forces_stall", stall, 1);
        hold = 1'b0;

        // Load-use: lw $3 tnew=2, addu reads $3 tuse=1 (rs) and tuse=2 (rt)
        tick(); wr(5'd3, 2'd2);
        @(negedge clk); chk("t1_lw_stall", stall, 0);
        tick(); drv(1'b1, 5'd3, 1'b1, 2'd1, 5'd3, 1'b1, 2'd2, 1'b1, 5'd4, 2'd1, 1'b0, 2'b00);
        @(negedge clk);
        chk("t1_stall", stall, 1);
        chk("t1_fwd1_e", fwd_a1, 1);
        chk("t1_fwd2_e", fwd_a2, 1);
        tick();
        @(negedge clk);
        chk("t1_stall_rel", stall, 0);
        chk("t1_fwd1_m", fwd_a1, 2);
        chk("t1_fwd2_m", fwd_a2, 2);
        drain();

        // ALU then branch with tuse=0 on rt
        tick(); wr(5'd5, 2'd1);
        tick(); drv(1'b1, 5'd0, 1'b0, 2'd0, 5'd5, 1'b1, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 2'b00);
        @(negedge clk);
        chk("t2_stall", stall, 1);
        chk("t2_fwd2_e", fwd_a2, 1);
        tick();
        @(negedge clk);
        chk("t2_stall_rel", stall, 0);
        chk("t2_fwd2_m", fwd_a2, 2);
        drain();

        // Youngest writer wins over a stale older record
        tick(); wr(5'd7, 2'd3);
        tick(); wr(5'd7, 2'd0);
        @(negedge clk); chk("t3_wr2_stall", stall, 0);
        tick(); drv(1'b1, 5'd7, 1'b1, 2'd0, 5'd7, 1'b0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 2'b00);
        @(negedge clk);
        chk("t3_fwd1_young", fwd_a1, 1);
        chk("t3_stall", stall, 0);
        chk("t3_fwd2_unused", fwd_a2, 0);
        drain();

        // MD busy counter: div, mult, and the 11 encoding behaving as div
        md_run("div", 2'b10, 10);
        md_run("mult", 2'b01, 5);
        md_run("md11", 2'b11, 10);

        // Hold freezes the lw record in E for three edges
        tick(); wr(5'd3, 2'd2);
        tick(); hold = 1'b1;
        drv(1'b1, 5'd3, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t5_hold_stall_%0d", i), stall, 1);
            chk($sformatf("t5_hold_fwd_%0d", i), fwd_a1, 1);
            tick();
        end
        hold = 1'b0;
        @(negedge clk);
        chk("t5_rel_stall_e", stall, 1);
        chk("t5_rel_fwd_e", fwd_a1, 1);
        tick();
        @(negedge clk);
        chk("t5_stall_m", stall, 1);
        chk("t5_fwd_m", fwd_a1, 2);
        tick();
        @(negedge clk);
        chk("t5_stall_w", stall, 0);
        chk("t5_fwd_w", fwd_a1, 3);
        drain();

        // Flush (together with hold) clears three live entries
        tick(); wr(5'd8, 2'd3);
        tick(); wr(5'd9, 2'd3);
        tick(); wr(5'd10, 2'd3);
        tick(); drv(1'b1, 5'd8, 1'b1, 2'd3, 5'd10, 1'b1, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 2'b00);
        @(negedge clk);
        chk("t6_pre_fwd1", fwd_a1, 3);
        chk("t6_pre_fwd2", fwd_a2, 1);
        chk("t6_pre_stall", stall, 0);
        flush = 1'b1; hold = 1'b1; idle();
        tick();
        flush = 1'b0; hold = 1'b0;
        drv(1'b1, 5'd8, 1'b1, 2'd0, 5'd10, 1'b1, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 2'b00);
        @(negedge clk);
        chk("t6_fl_fwd1", fwd_a1, 0);
        chk("t6_fl_fwd2", fwd_a2, 0);
        chk("t6_fl_stall", stall, 0);

        // Writes to $0 are never recorded
        tick(); wr(5'd0, 2'd3);
        tick(); drv(1'b1, 5'd0, 1'b1, 2'd0, 5'd0, 1'b1, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 2'b00);
        @(negedge clk);
        chk("t6_r0_stall", stall, 0);
        chk("t6_r0_fwd1", fwd_a1, 0);
        drain();

        // Reset mid-operation beats flush and issue
        tick(); drv(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 5'd12, 2'd3, 1'b1, 2'b10);
        tick(); reset = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("rm_pre_busy", md_busy, 1);
        tick(); reset = 1'b0; flush = 1'b0;
        drv(1'b1, 5'd12, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b1, 2'b00);
        @(negedge clk);
        chk("rm_stall", stall, 0);
        chk("rm_fwd1", fwd_a1, 0);
        chk("rm_busy", md_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
